buffer_loader: RTL and testbench
================================

// Module: buffer_loader
// PURPOSE
//  Upstream feeder for the west/north ping-pong bank buffers. Takes a narrow valid/ready word
//  stream and packs WORDS_PER_BEAT words into one bank-write beat (din + in_valid), which drives
//  the buffer top's *_bank0_din / in_valid_* inputs. Counts TOTAL_DEPTH beats per tile, then
//  stalls the stream until the buffer controller releases the tile. One instance per bank/lane.
// PARAMETERS
//  ELEM_WIDTH      64  width of one stream word (= one din slot, the IN_WIDTH of the bank)
//  WORDS_PER_BEAT   4  words packed per bank-write beat (= TOTAL_INPUT_W of the bank), >=1
//  TOTAL_DEPTH     16  beats per tile (= bank TOTAL_DEPTH), >=1
// PORTS
//  clk           in   1                             clock
//  rst_n         in   1                             async active-low reset
//  start         in   1                             pulse: arm loader (IDLE->FILL)
//  tile_release  in   1                             pulse: downstream finished with loaded tile
//  s_valid       in   1                             stream word valid
//  s_ready       out  1                             stream word ready
//  s_data        in   ELEM_WIDTH                    stream word
//  s_last        in   1                             marks final word of a tile (checked only with macro)
//  din           out  ELEM_WIDTH x [WORDS_PER_BEAT] unpacked packed-beat, slot 0 = first word
//  in_valid      out  1                             one-cycle beat-write strobe
//  load_done     out  1                             one-cycle pulse with final beat of tile
//  busy          out  1                             high in FILL or WAIT_REL
//  tile_cnt      out  16                            tiles completed, wraps at 2^16
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; s_ready, in_valid, load_done, busy=0; din all 0;
//    word_cnt, beat_cnt, tile_cnt=0; release_pend=0. Reset mid-tile discards partial beat.
//  - FSM: IDLE -start-> FILL; FILL -last word of last beat accepted-> WAIT_REL (or FILL if
//    release_pend); WAIT_REL -tile_release-> FILL. start outside IDLE ignored.
//  - s_ready = (state==FILL), combinational from state only; never depends on s_valid.
//  - Accept = s_valid & s_ready. Word placed in pack reg slot word_cnt; word_cnt++ (mod WPB).
//  - On accept with word_cnt==WORDS_PER_BEAT-1: next cycle din <= full pack reg, in_valid=1
//    for exactly one cycle (latency 1 cycle from final word's accept). din holds until next beat.
//  - beat_cnt++ per beat; beat with beat_cnt==TOTAL_DEPTH-1 also raises load_done the same
//    cycle as its in_valid, tile_cnt++, beat_cnt->0.
//  - tile_release in FILL sets release_pend; on tile completion with release_pend set, FSM stays
//    in FILL (s_ready never drops), release_pend clears. tile_release in IDLE dropped.
//    tile_release the same cycle as final-word accept counts as pending. Second release while
//    pending is not counted (no queueing beyond one).
//  - WORDS_PER_BEAT=1: every accepted word is a beat. TOTAL_DEPTH=1: every beat ends a tile.
// CONFIGURATION
//  BUFFER_LOADER_LAST_CHECK_EN defined: adds output last_err (1b, sticky, reset 0). Set when
//    s_last=1 on an accepted word that is not the tile's final word, or s_last=0 on the final
//    word. Data flow unaffected. Cleared only by reset.
//  Undefined: s_last ignored, no last_err port.
// TESTING
//  - Reset, start, WPB=4, DEPTH=2, stream 0..7 back-to-back -> in_valid at cycles after words
//    3 and 7, din={0,1,2,3} then {4,5,6,7}; load_done with 2nd beat; tile_cnt=1; s_ready=0.
//  - Random s_valid gaps (50%) over 3 tiles with release after each -> beat contents in order,
//    exactly 2 in_valid per tile, no word lost or duplicated.
//  - tile_release pulsed mid-tile (beat 0) -> at tile end s_ready stays 1, next word accepted
//    next cycle, busy stays 1, tile_cnt=1.
//  - tile_release same cycle as final word accept -> no WAIT_REL stall; second pulse in
//    WAIT_REL-free period not queued (following tile stalls in WAIT_REL).
//  - rst_n asserted after 2 words of a beat -> outputs 0 immediately; after start, stream
//    10..13 -> din={10,11,12,13}.
//  - Macro on: s_last on word 5 of 8 -> last_err=1 and stays 1; data beats unchanged.

Source files
------------

// File: rtl/buffer_loader.sv
// Packs a valid/ready word stream into bank-write beats and counts beats per tile, stalling until release.
// Optional BUFFER_LOADER_LAST_CHECK_EN adds a sticky last_err_o output that checks s_last_i framing.
//
// state       | meaning
// ST_IDLE     | not armed, stream stalled
// ST_FILL     | accepting words and emitting beats
// ST_WAIT_REL | tile loaded, stalled until tile_release_i
module buffer_loader #(
   parameter int ELEM_WIDTH     = 64,
   parameter int WORDS_PER_BEAT = 4,
   parameter int TOTAL_DEPTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  tile_release_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [ELEM_WIDTH-1:0] s_data_i,
   input  logic                  s_last_i,
   output logic [ELEM_WIDTH-1:0] din_o [WORDS_PER_BEAT],
   output logic                  in_valid_o,
   output logic                  load_done_o,
   output logic                  busy_o,
   output logic [15:0]           tile_cnt_o
`ifdef BUFFER_LOADER_LAST_CHECK_EN
   ,
   output logic                  last_err_o
`endif
);

   localparam int WC_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
   localparam int BC_W = (TOTAL_DEPTH > 1) ? $clog2(TOTAL_DEPTH) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_BEAT - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(TOTAL_DEPTH - 1);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_FILL     = 2'd1;
   localparam logic [1:0] ST_WAIT_REL = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  release_pend_q, release_pend_d;
   logic [WC_W-1:0]       word_cnt_q;
   logic [BC_W-1:0]       beat_cnt_q;
   logic [15:0]           tile_cnt_q;
   logic                  in_valid_q;
   logic                  load_done_q;
   logic [ELEM_WIDTH-1:0] pack_q    [WORDS_PER_BEAT];
   logic [ELEM_WIDTH-1:0] din_q     [WORDS_PER_BEAT];
   logic [ELEM_WIDTH-1:0] beat_full [WORDS_PER_BEAT];

   logic accept;
   logic beat_end;
   logic tile_end;

   assign s_ready_o   = (state_q == ST_FILL);
   assign busy_o      = (state_q != ST_IDLE);
   assign in_valid_o  = in_valid_q;
   assign load_done_o = load_done_q;
   assign tile_cnt_o  = tile_cnt_q;
   assign din_o       = din_q;

   assign accept   = s_valid_i & s_ready_o;
   assign beat_end = accept && (word_cnt_q == WC_LAST);
   assign tile_end = beat_end && (beat_cnt_q == BC_LAST);

   // The word arriving now completes the beat, so it bypasses the pack register.
   always_comb begin
      for (int i = 0; i < WORDS_PER_BEAT; i++) begin
         beat_full[i] = (word_cnt_q == WC_W'(i)) ? s_data_i : pack_q[i];
      end
   end

   always_comb begin
      state_d        = state_q;
      release_pend_d = release_pend_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (tile_release_i) release_pend_d = 1'b1;
            if (tile_end) begin
               if (release_pend_q || tile_release_i) release_pend_d = 1'b0;
               else                                  state_d        = ST_WAIT_REL;
            end
         end
         ST_WAIT_REL: begin
            if (tile_release_i) state_d = ST_FILL;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         release_pend_q <= 1'b0;
         word_cnt_q     <= '0;
         beat_cnt_q     <= '0;
         tile_cnt_q     <= '0;
         in_valid_q     <= 1'b0;
         load_done_q    <= 1'b0;
         for (int i = 0; i < WORDS_PER_BEAT; i++) begin
            pack_q[i] <= '0;
            din_q[i]  <= '0;
         end
      end else begin
         state_q        <= state_d;
         release_pend_q <= release_pend_d;
         in_valid_q     <= beat_end;
         load_done_q    <= tile_end;
         if (accept) begin
            pack_q[word_cnt_q] <= s_data_i;
            word_cnt_q         <= beat_end ? '0 : word_cnt_q + WC_W'(1);
         end
         if (beat_end) begin
            din_q      <= beat_full;
            beat_cnt_q <= tile_end ? '0 : beat_cnt_q + BC_W'(1);
         end
         if (tile_end) tile_cnt_q <= tile_cnt_q + 16'd1;
      end
   end

`ifdef BUFFER_LOADER_LAST_CHECK_EN
   logic last_err_q;

   assign last_err_o = last_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                last_err_q <= 1'b0;
      else if (accept && (s_last_i != tile_end)) last_err_q <= 1'b1;
   end
`else
   logic unused_s_last;
   assign unused_s_last = s_last_i;
`endif

endmodule

// File: tb/tb_buffer_loader.sv
// Randomized and directed bench for buffer_loader; a queue-based model predicts every output each cycle.
// Small geometry: 16-bit words, 4 words per beat, 2 beats per tile.
module tb_buffer_loader;

   localparam int EW  = 16;
   localparam int WPB = 4;
   localparam int D   = 2;
   localparam int TW  = WPB * D;

   typedef logic [EW-1:0] word_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   logic  start = 1'b0;
   logic  tile_release = 1'b0;
   logic  s_valid = 1'b0;
   logic  s_ready;
   word_t s_data = '0;
   logic  s_last = 1'b0;
   word_t din_w [WPB];
   logic  in_valid;
   logic  load_done;
   logic  busy;
   logic [15:0] tile_cnt;
`ifdef BUFFER_LOADER_LAST_CHECK_EN
   logic  last_err;
`endif

   buffer_loader #(.ELEM_WIDTH(EW), .WORDS_PER_BEAT(WPB), .TOTAL_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .tile_release_i(tile_release),
      .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
      .din_o(din_w), .in_valid_o(in_valid), .load_done_o(load_done), .busy_o(busy),
      .tile_cnt_o(tile_cnt)
`ifdef BUFFER_LOADER_LAST_CHECK_EN
      , .last_err_o(last_err)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: 0 idle, 1 filling, 2 stalled for release
   int        m_mode;
   bit        m_pend;
   word_t     m_part[$];
   int        m_beats;
   logic [15:0] m_tiles;
   word_t     e_din [WPB];
   bit        e_iv, e_ld, e_err;
   bit        m_acc_last;

   logic [WPB*EW-1:0] beat_log[$];
   int        iv_cnt = 0;
   int        ld_cnt = 0;
   int        widx   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_pend = 0; m_part.delete(); m_beats = 0; m_tiles = '0;
      for (int i = 0; i < WPB; i++) e_din[i] = '0;
      e_iv = 0; e_ld = 0; e_err = 0; m_acc_last = 0;
   endfunction

   // Predict outputs after the coming rising edge from the inputs held across it.
   function automatic void model_step();
      int pos;
      e_iv = 0; e_ld = 0; m_acc_last = 0;
      if (m_mode == 0) begin
         if (start) m_mode = 1;
      end else if (m_mode == 1) begin
         if (tile_release) m_pend = 1;
         if (s_valid) begin
            m_acc_last = 1;
            pos = m_beats * WPB + m_part.size();
            if (s_last != (pos == TW - 1)) e_err = 1;
            m_part.push_back(s_data);
            if (m_part.size() == WPB) begin
               for (int i = 0; i < WPB; i++) e_din[i] = m_part[i];
               m_part.delete();
               e_iv = 1;
               m_beats++;
               if (m_beats == D) begin
                  m_beats = 0;
                  e_ld = 1;
                  m_tiles++;
                  if (m_pend) m_pend = 0;
                  else        m_mode = 2;
               end
            end
         end
      end else begin
         if (tile_release) m_mode = 1;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("s_ready", s_ready, m_mode == 1);
      chk("busy", busy, m_mode != 0);
      chk("in_valid", in_valid, e_iv);
      chk("load_done", load_done, e_ld);
      chk("tile_cnt", tile_cnt, m_tiles);
      for (int i = 0; i < WPB; i++) chk("din", din_w[i], e_din[i]);
`ifdef BUFFER_LOADER_LAST_CHECK_EN
      chk("last_err", last_err, e_err);
`endif
      if (in_valid === 1'b1) begin
         beat_log.push_back({din_w[0], din_w[1], din_w[2], din_w[3]});
         iv_cnt++;
      end
      if (load_done === 1'b1) ld_cnt++;
      if (rst_n) model_step();
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic pulse_rel();
      tile_release = 1'b1; cyc(); tile_release = 1'b0;
   endtask

   task automatic send(input word_t d, input bit gaps, input bit bad_last, output int n);
      if (gaps) for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) cyc();
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (widx == TW - 1) ^ bad_last;
      n = 0;
      do begin
         cyc();
         n++;
      end while (!m_acc_last && n < 200);
      if (n >= 200) begin
         bad++;
         $display("FAIL send_timeout actual=%0d expected=<200", n);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      widx = (widx + 1) % TW;
   endtask

   task automatic send_n(input int cnt, input word_t base, input bit gaps);
      int n;
      for (int k = 0; k < cnt; k++) send(gaps ? word_t'($urandom) : base + word_t'(k), gaps, 1'b0, n);
   endtask

   initial begin
      int n, iv0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();

      // back-to-back tile 0..7
      pulse_start();
      send_n(8, 16'd0, 1'b0);
      cyc(); cyc();
      chk("t1_beats", beat_log.size(), 2);
      if (beat_log.size() == 2) begin
         chk("t1_beat0", beat_log[0], 64'h0000_0001_0002_0003);
         chk("t1_beat1", beat_log[1], 64'h0004_0005_0006_0007);
      end
      chk("t1_tile_cnt", tile_cnt, 1);
      chk("t1_ready", s_ready, 0);
      chk("t1_load_done_cnt", ld_cnt, 1);

      // random gaps, three tiles, release after each stall
      for (int t = 0; t < 3; t++) begin
         pulse_rel();
         iv0 = iv_cnt;
         send_n(8, 16'd0, 1'b1);
         cyc(); cyc(); cyc();
         chk("t2_beats_per_tile", iv_cnt - iv0, 2);
      end
      chk("t2_tile_cnt", tile_cnt, 4);

      // release during beat 0 keeps the stream flowing at tile end
      pulse_rel();
      send_n(2, 16'h100, 1'b0);
      pulse_rel();
      send_n(6, 16'h102, 1'b0);
      chk("t3_ready_kept", s_ready, 1);
      chk("t3_busy", busy, 1);
      send(16'h200, 1'b0, 1'b0, n);
      chk("t3_next_latency", n, 1);
      chk("t3_tile_cnt", tile_cnt, 5);
      send_n(7, 16'h201, 1'b0);
      cyc();
      chk("t3_stall", s_ready, 0);

      // two releases in one tile count once
      pulse_rel();
      send_n(2, 16'h300, 1'b0);
      pulse_rel();
      cyc();
      pulse_rel();
      send_n(14, 16'h302, 1'b0);
      cyc();
      chk("t4_no_queue", s_ready, 0);
      chk("t4_tile_cnt", tile_cnt, 8);

      // release coincident with final word
      pulse_rel();
      send_n(7, 16'h400, 1'b0);
      tile_release = 1'b1;
      send(16'h407, 1'b0, 1'b0, n);
      tile_release = 1'b0;
      send(16'h408, 1'b0, 1'b0, n);
      chk("t4_same_cycle_latency", n, 1);
      send_n(7, 16'h409, 1'b0);
      cyc();
      chk("t4_stall_after", s_ready, 0);
      chk("t4_tile_cnt2", tile_cnt, 10);

      // reset after two words of a beat
      pulse_rel();
      send_n(2, 16'h500, 1'b0);
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("t5_in_valid", in_valid, 0);
      chk("t5_din0", din_w[0], 0);
      chk("t5_tile_cnt", tile_cnt, 0);
      chk("t5_busy", busy, 0);
      cyc();
      rst_n = 1'b1;
      widx = 0;
      cyc();
      pulse_start();
      send_n(4, 16'd10, 1'b0);
      cyc(); cyc();
      chk("t5_beat", beat_log[beat_log.size()-1], 64'h000a_000b_000c_000d);

`ifdef BUFFER_LOADER_LAST_CHECK_EN
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      widx = 0;
      cyc();
      pulse_start();
      for (int k = 0; k < 8; k++) send(word_t'(16'h600 + k), 1'b0, k == 5, n);
      cyc(); cyc();
      chk("t6_last_err", last_err, 1);
      chk("t6_beat", beat_log[beat_log.size()-1], 64'h0604_0605_0606_0607);
      repeat (3) cyc();
      chk("t6_sticky", last_err, 1);
`endif

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
